ldst_seq: RTL and testbench
===========================

Name: ldst_seq

Overview:
- Load/store sequencer directly upstream of the byte-addressable data memory.
- Accepts one load or store request at a time from the execute stage.
- Computes the effective address as base plus signed 8-bit offset.
- Splits 16-bit (wide) accesses into two byte accesses, little-endian, and drives the memory's read address, write address, write data and write strobe.
- Captures load bytes from the memory's combinational read output and returns a completion response to the pipeline.

Parameters:
- ADDR_W, 16, effective address / memory address width.
- DATA_W, 8, memory byte width; wide transfers are 2*DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_wide  in  1  1 = 16-bit access, 0 = 8-bit access
- req_base  in  16  base address from register pair
- req_offset  in  8  signed displacement
- req_wdata  in  16  store data; [7:0] used for byte stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  16  load data, valid with resp_valid
- resp_fault  out  1  access aborted, valid with resp_valid
- data_rd_addr  out  16  memory read address
- data_wr_addr  out  16  memory write address
- datamem_wr_data  out  8  memory write data
- store_to_mem  out  1  memory write strobe
- dmem_dout  in  8  memory read data, combinational from data_rd_addr

Behaviour:
- Reset:
  - Reset is sampled at the rising edge of clk while low.
  - Forces state IDLE.
  - Drives req_ready=0 during the reset cycle and 1 on the first cycle after release.
  - Drives resp_valid=0, resp_fault=0, resp_rdata=0, data_rd_addr=0, data_wr_addr=0, datamem_wr_data=0, store_to_mem=0.
- Registered outputs: every output is registered.
- Handshake: a request is accepted at the edge where req_valid & req_ready. The request fields are captured then; later changes to the inputs are ignored.
- Effective address: ea = req_base + sign_extend(req_offset), modulo 2^16. For example, 0x0010 + 0xF0 = 0x0000.
- State machine IDLE -> LO -> (HI if wide) -> DONE -> IDLE:
  - IDLE: req_ready=1, store_to_mem=0. On accept, go to LO.
  - LO:
    - data_rd_addr = data_wr_addr = ea.
    - For stores: store_to_mem=1, datamem_wr_data = wdata[7:0].
    - For loads: at the end of the cycle, capture dmem_dout into rdata[7:0].
  - HI (wide only):
    - Addresses = ea+1, modulo 2^16.
    - For stores: store_to_mem=1, data = wdata[15:8].
    - For loads: capture dmem_dout into rdata[15:8].
  - DONE:
    - resp_valid=1 for exactly one cycle; store_to_mem=0; addresses hold their last value.
    - resp_rdata = captured data; byte loads are zero-extended. Stores return resp_rdata=0.
- Latency, measured from the accept edge to resp_valid high:
  - byte access: 2 cycles
  - wide access: 3 cycles
  - req_ready is low from the accept edge until IDLE is re-entered, so back-to-back throughput is one request per 3 (byte) or 4 (wide) cycles.
- A request presented while not in IDLE is not accepted; the requester must hold req_valid.
- Reset mid-operation:
  - A write whose strobe is high at the reset edge still commits, because the memory has no reset.
  - No further strobes are issued, no response is produced, and the partial load data is discarded.
- resp_fault is 0 unless the optional feature below is compiled in.

Optional Feature:
- Macro LDST_WRAP_FAULT_EN.
- Defined:
  - A wide request with ea = 0xFFFF goes IDLE -> DONE directly.
  - No memory strobe is issued and store_to_mem stays 0.
  - resp_valid=1 with resp_fault=1 and resp_rdata=0.
- Undefined: the high byte wraps to address 0x0000, and resp_fault is tied to 0.

Test Plan:
- Reset low for 2 cycles with req_valid=1 -> all outputs 0 and no accept; req_ready=1 on the cycle after release.
- Byte store base=0x1234, off=0x05, wdata=0x00AB -> one cycle with store_to_mem=1, wr_addr=0x1239, data 0xAB. Then a byte load from the same address -> resp_rdata=0x00AB, 2 cycles after accept.
- Wide store base=0x2000, off=0xFF (-1), wdata=0xBEEF -> writes 0xEF@0x1FFF then 0xBE@0x2000. A wide load from there -> resp_rdata=0xBEEF, 3 cycles after accept.
- Wide load with ea=0xFFFF, mem[0xFFFF]=0x11, mem[0x0000]=0x22:
  - without macro -> resp_rdata=0x2211, resp_fault=0
  - with macro -> resp_fault=1, rdata=0, no memory access
- req_valid held high with a second request during LO/HI -> req_ready=0 and the second request is not accepted. It is accepted in the IDLE cycle after DONE with the held fields.
- Reset asserted during HI of a wide store -> the strobe sampled at the reset edge commits, no resp_valid follows, and the unit returns to IDLE.

Source files
------------

// File: rtl/ldst_seq_if.sv
// ---------------------------------------------------------------------------
// ldst_seq_if : bundle between the execute stage, the load/store sequencer
// and the byte-wide data memory.
//
// Request side (execute stage -> sequencer):
//   req_valid, req_ready, req_is_store, req_wide, req_base, req_offset,
//   req_wdata
// Response side (sequencer -> execute stage):
//   resp_valid, resp_rdata, resp_fault
// Memory side (sequencer <-> data memory):
//   data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem, dmem_dout
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment (pipeline plus memory), e.g. a testbench
// ---------------------------------------------------------------------------
interface ldst_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic                  req_wide;
    logic [ADDR_W-1:0]     req_base;
    logic [7:0]            req_offset;
    logic [2*DATA_W-1:0]   req_wdata;

    logic                  resp_valid;
    logic [2*DATA_W-1:0]   resp_rdata;
    logic                  resp_fault;

    logic [ADDR_W-1:0]     data_rd_addr;
    logic [ADDR_W-1:0]     data_wr_addr;
    logic [DATA_W-1:0]     datamem_wr_data;
    logic                  store_to_mem;
    logic [DATA_W-1:0]     dmem_dout;

    modport slave (
        input  req_valid, req_is_store, req_wide, req_base, req_offset,
               req_wdata, dmem_dout,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem
    );

    modport master (
        output req_valid, req_is_store, req_wide, req_base, req_offset,
               req_wdata, dmem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               data_rd_addr, data_wr_addr, datamem_wr_data, store_to_mem
    );
endinterface

// File: rtl/ldst_seq.sv
// ---------------------------------------------------------------------------
// ldst_seq : load/store sequencer in front of the byte-addressable data
// memory.
//
// Takes one load/store request at a time, forms ea = base + sext(offset),
// splits 16-bit accesses into two little-endian byte accesses (ea, ea+1),
// drives the memory address/data/strobe, captures load bytes from the
// memory's combinational read port and returns a one-cycle response.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-low reset
//   bus    - ldst_seq_if.slave (request, response and memory signals)
//
// Every output is registered. Sequence: IDLE -> LO -> (HI if wide) -> DONE.
//
// Build option:
//   LDST_WRAP_FAULT_EN - when defined, a wide access at ea = all-ones is
//   aborted (no memory strobe, resp_fault=1, resp_rdata=0). When undefined
//   the high byte wraps to address 0 and resp_fault is always 0.
// ---------------------------------------------------------------------------
module ldst_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    ldst_seq_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                state, state_next;

    // captured request fields
    logic [ADDR_W-1:0]     ea;
    logic [DATA_W-1:0]     wdata_hi;
    logic                  is_store;
    logic                  wide;
    logic [DATA_W-1:0]     rdata_lo, rdata_lo_next;

    // output registers and their next values
    logic                  ready, ready_next;
    logic                  resp_valid, resp_valid_next;
    logic                  resp_fault, resp_fault_next;
    logic [2*DATA_W-1:0]   resp_rdata, resp_rdata_next;
    logic [ADDR_W-1:0]     mem_addr, mem_addr_next;
    logic [DATA_W-1:0]     wr_data, wr_data_next;
    logic                  strobe, strobe_next;

    logic                  accept;
    logic                  wrap_fault;
    logic [ADDR_W-1:0]     ea_in;

    function automatic logic [ADDR_W-1:0] calc_ea(
        input logic [ADDR_W-1:0] base,
        input logic signed [7:0] off
    );
        return base + {{(ADDR_W-8){off[7]}}, off};
    endfunction

    assign ea_in  = calc_ea(bus.req_base, bus.req_offset);
    assign accept = (state == IDLE) && ready && bus.req_valid;

`ifdef LDST_WRAP_FAULT_EN
    // the second byte of a wide access at the top address would wrap
    assign wrap_fault = bus.req_wide && (ea_in == {ADDR_W{1'b1}});
`else
    assign wrap_fault = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        ready_next      = 1'b0;
        resp_valid_next = 1'b0;
        resp_fault_next = 1'b0;
        resp_rdata_next = resp_rdata;
        mem_addr_next   = mem_addr;
        wr_data_next    = wr_data;
        strobe_next     = 1'b0;
        rdata_lo_next   = rdata_lo;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (wrap_fault) begin
                        state_next      = DONE;
                        resp_valid_next = 1'b1;
                        resp_fault_next = 1'b1;
                        resp_rdata_next = '0;
                    end else begin
                        state_next    = LO;
                        mem_addr_next = ea_in;
                        strobe_next   = bus.req_is_store;
                        wr_data_next  = bus.req_wdata[DATA_W-1:0];
                    end
                end else begin
                    ready_next = 1'b1;
                end
            end

            LO: begin
                // memory read port is combinational from mem_addr = ea
                rdata_lo_next = bus.dmem_dout;
                if (wide) begin
                    state_next    = HI;
                    mem_addr_next = ea + {{(ADDR_W-1){1'b0}}, 1'b1};
                    strobe_next   = is_store;
                    wr_data_next  = wdata_hi;
                end else begin
                    state_next      = DONE;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = is_store ? '0
                                               : {{DATA_W{1'b0}}, bus.dmem_dout};
                end
            end

            HI: begin
                state_next      = DONE;
                resp_valid_next = 1'b1;
                resp_rdata_next = is_store ? '0 : {bus.dmem_dout, rdata_lo};
            end

            DONE: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            wr_data    <= '0;
            strobe     <= 1'b0;
        end else begin
            state      <= state_next;
            ready      <= ready_next;
            resp_valid <= resp_valid_next;
            resp_fault <= resp_fault_next;
            resp_rdata <= resp_rdata_next;
            mem_addr   <= mem_addr_next;
            wr_data    <= wr_data_next;
            strobe     <= strobe_next;
        end
    end

    // request capture; the fields are only consulted after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            ea       <= ea_in;
            wdata_hi <= bus.req_wdata[2*DATA_W-1:DATA_W];
            is_store <= bus.req_is_store;
            wide     <= bus.req_wide;
        end
        rdata_lo <= rdata_lo_next;
    end

    assign bus.req_ready       = ready;
    assign bus.resp_valid      = resp_valid;
    assign bus.resp_fault      = resp_fault;
    assign bus.resp_rdata      = resp_rdata;
    assign bus.data_rd_addr    = mem_addr;
    assign bus.data_wr_addr    = mem_addr;
    assign bus.datamem_wr_data = wr_data;
    assign bus.store_to_mem    = strobe;

endmodule

// File: tb/tb_ldst_seq.sv
// ---------------------------------------------------------------------------
// tb_ldst_seq : self-checking bench for ldst_seq.
// A byte-array memory is attached to the memory side; an abstract reference
// model (a second byte array plus access rules) predicts the response data,
// latency and the write sequence of every request.
// ---------------------------------------------------------------------------
module tb_ldst_seq;

`ifdef LDST_WRAP_FAULT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ldst_seq_if #(.ADDR_W(16), .DATA_W(8)) bus();

    ldst_seq #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // data memory: combinational read, write on rising edge, no reset
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign bus.dmem_dout = mem[bus.data_rd_addr];

    always @(posedge clk) begin
        if (bus.store_to_mem === 1'b1)
            mem[bus.data_wr_addr] <= bus.datamem_wr_data;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // expectations for the request currently in flight
    logic [15:0] e_rdata;
    logic        e_fault;
    int          e_lat;
    int          e_nwr;
    logic [15:0] e_addr [2];
    logic [7:0]  e_data [2];

    task automatic model_txn(input bit st, input bit w, input logic [15:0] base,
                             input logic [7:0] off, input logic [15:0] wd);
        logic [15:0] ea;
        logic [15:0] ea1;
        ea  = base + {{8{off[7]}}, off};
        ea1 = ea + 16'd1;
        e_rdata = 16'h0000;
        e_fault = 1'b0;
        e_nwr   = 0;
        e_lat   = w ? 3 : 2;
        e_addr[0] = ea;  e_data[0] = wd[7:0];
        e_addr[1] = ea1; e_data[1] = wd[15:8];
        if (WRAP_EN && w && ea == 16'hFFFF) begin
            e_fault = 1'b1;
            e_lat   = 1;
        end else if (st) begin
            e_nwr = w ? 2 : 1;
            ref_mem[ea] = wd[7:0];
            if (w) ref_mem[ea1] = wd[15:8];
        end else begin
            e_rdata = w ? {ref_mem[ea1], ref_mem[ea]} : {8'h00, ref_mem[ea]};
        end
    endtask

    task automatic set_req(input bit st, input bit w, input logic [15:0] base,
                           input logic [7:0] off, input logic [15:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_wide     = w;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
    endtask

    task automatic scramble();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'($urandom);
        bus.req_wide     = 1'($urandom);
        bus.req_base     = 16'($urandom);
        bus.req_offset   = 8'($urandom);
        bus.req_wdata    = 16'($urandom);
    endtask

    // called at a sample point with req_valid high; returns at the sample
    // point of the first cycle after the accept edge
    task automatic wait_accept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s accept: req_ready never 1 within 20 cycles", tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic monitor_txn(input string tag);
        int nwr;
        int lat;
        logic [15:0] oa [2];
        logic [7:0]  od [2];
        nwr = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_ready cyc %0d: got %b want 0", tag, cyc, bus.req_ready);
            end
            if (bus.store_to_mem === 1'b1) begin
                if (nwr < 2) begin
                    oa[nwr] = bus.data_wr_addr;
                    od[nwr] = bus.datamem_wr_data;
                end
                nwr++;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lat != e_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
        end
        n_cmp++;
        if (bus.resp_rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, bus.resp_rdata, e_rdata);
        end
        n_cmp++;
        if (bus.resp_fault !== e_fault) begin
            n_fail++;
            $display("FAIL %s fault: got %b want %b", tag, bus.resp_fault, e_fault);
        end
        n_cmp++;
        if (nwr != e_nwr) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", tag, nwr, e_nwr);
        end
        for (int i = 0; i < e_nwr && i < nwr; i++) begin
            n_cmp++;
            if (oa[i] !== e_addr[i] || od[i] !== e_data[i]) begin
                n_fail++;
                $display("FAIL %s write%0d: got %h@%h want %h@%h",
                         tag, i, od[i], oa[i], e_data[i], e_addr[i]);
            end
        end
    endtask

    task automatic do_req(input string tag, input bit st, input bit w,
                          input logic [15:0] base, input logic [7:0] off,
                          input logic [15:0] wd);
        model_txn(st, w, base, off, wd);
        set_req(st, w, base, off, wd);
        wait_accept(tag);
        scramble();
        monitor_txn(tag);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", tag, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(1'b1, 1'b0, 16'h0100, 8'h00, 16'h00AA);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 ||
                bus.resp_fault !== 1'b0 || bus.resp_rdata !== 16'h0 ||
                bus.data_rd_addr !== 16'h0 || bus.data_wr_addr !== 16'h0 ||
                bus.datamem_wr_data !== 8'h0 || bus.store_to_mem !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rdy=%b rv=%b f=%b rd=%h ra=%h wa=%h wd=%h st=%b want all 0",
                         bus.req_ready, bus.resp_valid, bus.resp_fault, bus.resp_rdata,
                         bus.data_rd_addr, bus.data_wr_addr, bus.datamem_wr_data,
                         bus.store_to_mem);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.store_to_mem !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b st=%b rv=%b want 1 0 0",
                     bus.req_ready, bus.store_to_mem, bus.resp_valid);
        end
        scramble();
    endtask

    task automatic test_byte();
        do_req("byte_st", 1'b1, 1'b0, 16'h1234, 8'h05, 16'h00AB);
        do_req("byte_ld", 1'b0, 1'b0, 16'h1234, 8'h05, 16'($urandom));
        do_req("negoff_st", 1'b1, 1'b0, 16'h0010, 8'hF0, 16'h5577);
        do_req("negoff_ld", 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000);
    endtask

    task automatic test_wide();
        do_req("wide_st", 1'b1, 1'b1, 16'h2000, 8'hFF, 16'hBEEF);
        do_req("wide_ld", 1'b0, 1'b1, 16'h2000, 8'hFF, 16'($urandom));
        do_req("wide_hi_ld", 1'b0, 1'b0, 16'h2000, 8'h00, 16'h0000);
    endtask

    task automatic test_wrap();
        do_req("wrap_st_ff", 1'b1, 1'b0, 16'hFFFF, 8'h00, 16'h0011);
        do_req("wrap_st_00", 1'b1, 1'b0, 16'h0000, 8'h00, 16'h0022);
        do_req("wrap_ld", 1'b0, 1'b1, 16'hFFFF, 8'h00, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd;
        logic [15:0] base;
        for (int w = 0; w < 2; w++) begin
            wd   = 16'($urandom);
            base = 16'h3000 + 16'(w * 16);
            model_txn(1'b1, w[0], base, 8'h00, wd);
            set_req(1'b1, w[0], base, 8'h00, wd);
            wait_accept("b2b_a");
            // second request held during the busy cycles
            set_req(1'b0, w[0], base, 8'h00, 16'h0000);
            monitor_txn("b2b_a");
            @(posedge clk); #1;
            n_cmp++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle_ready: got %b want 1", bus.req_ready);
            end
            model_txn(1'b0, w[0], base, 8'h00, 16'h0000);
            @(posedge clk); #1;
            scramble();
            monitor_txn("b2b_b");
            @(posedge clk); #1;
            n_cmp++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_end_ready: got %b want 1", bus.req_ready);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] wd;
        bit seen;
        wd = 16'($urandom);
        model_txn(1'b1, 1'b1, 16'h4000, 8'h10, wd);
        set_req(1'b1, 1'b1, 16'h4000, 8'h10, wd);
        wait_accept("mid_rst");
        scramble();
        n_cmp++;
        if (bus.store_to_mem !== 1'b1 || bus.data_wr_addr !== 16'h4010 ||
            bus.datamem_wr_data !== wd[7:0]) begin
            n_fail++;
            $display("FAIL mid_rst_lo: got st=%b %h@%h want 1 %h@4010",
                     bus.store_to_mem, bus.datamem_wr_data, bus.data_wr_addr, wd[7:0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.store_to_mem !== 1'b1 || bus.data_wr_addr !== 16'h4011 ||
            bus.datamem_wr_data !== wd[15:8]) begin
            n_fail++;
            $display("FAIL mid_rst_hi: got st=%b %h@%h want 1 %h@4011",
                     bus.store_to_mem, bus.datamem_wr_data, bus.data_wr_addr, wd[15:8]);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.store_to_mem !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_state: got st=%b rv=%b rdy=%b want 0 0 0",
                     bus.store_to_mem, bus.resp_valid, bus.req_ready);
        end
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1 || bus.store_to_mem === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_rst_quiet: got resp/strobe activity after reset want none");
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_ready: got %b want 1", bus.req_ready);
        end
        do_req("mid_rst_ld", 1'b0, 1'b1, 16'h4000, 8'h10, 16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] rb [10];
        logic [7:0]  ro [10];
        bit          rw [10];
        logic [15:0] ea;
        bit          lw;
        for (int i = 0; i < 10; i++) begin
            rb[i] = 16'($urandom);
            ro[i] = 8'($urandom);
            rw[i] = 1'($urandom);
            ea = rb[i] + {{8{ro[i][7]}}, ro[i]};
            if (ea == 16'hFFFF) rb[i] = rb[i] ^ 16'h0100;
            do_req("rand_st", 1'b1, rw[i], rb[i], ro[i], 16'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            lw = rw[i] ? 1'($urandom) : 1'b0;
            do_req("rand_ld", 1'b0, lw, rb[i], ro[i], 16'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        scramble();
        test_reset();
        test_byte();
        test_wide();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
